// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: ROB ids, the CDB broadcast record and the CDB requester indices.
// Used by cdb_arbiter (arbitration mode selected with CDB_ARB_RR_EN).
package tomasulo_pkg;

    localparam int TAG_W  = 8;
    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam int ROB_AW = 5;

    typedef logic [ROB_AW-1:0] robid_t;

    typedef struct packed {
        logic              vld;
        logic [TAG_W-1:0]  tag;
        logic [REG_AW-1:0] wa;
        logic [XLEN-1:0]   wdata;
        robid_t            robid;
    } cdb_t;

    localparam int CDB_W = $bits(cdb_t);

    localparam int CDB_REQ_N = 3;

    typedef enum logic [1:0] {
        CDB_REQ_LOGIC = 2'd0,
        CDB_REQ_ARITH = 2'd1,
        CDB_REQ_MPY   = 2'd2
    } cdb_req_t;

endpackage

// File: rtl/cdb_arb_rr.sv
// One-hot grant over N request bits. With CDB_ARB_RR_EN defined: round-robin
// starting after the last winner; otherwise fixed priority, highest index first.
module cdb_arb_rr #(
    parameter int N = 3
) (
`ifdef CDB_ARB_RR_EN
    input  logic         clk,
    input  logic         rst_n,
`endif
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

`ifdef CDB_ARB_RR_EN
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        idx    = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IW'((int'(last_q) + off) % N);
            if (gnt_o == '0 && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                last_d     = idx;
            end
        end
    end

    // last_d only moves off last_q when a grant is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per FU pipe, one registered broadcast per cycle.
// Arbitration policy set by CDB_ARB_RR_EN (round-robin) or its absence (fixed, mpy first).
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int N = CDB_REQ_N
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_vld,
    input  logic [N*CDB_W-1:0] req_cdb,
    output logic [N-1:0]       req_rdy,
    input  logic               flush,
    output logic [CDB_W-1:0]   cdb_o,
    output logic               busy
);

    cdb_t         hold_q [N];
    logic [N-1:0] hold_vld_q, hold_vld_d;
    logic [N-1:0] gnt;
    logic [N-1:0] xfer;
    logic [N-1:0] arb_req;
    cdb_t         cdb_q, cdb_d;

    // Grant depends only on held state and flush, keeping req_vld off the ready path
    assign arb_req = hold_vld_q & {N{~flush}};

    cdb_arb_rr #(.N(N)) u_arb (
`ifdef CDB_ARB_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .req_i (arb_req),
        .gnt_o (gnt)
    );

    assign req_rdy = {N{~flush}} & (~hold_vld_q | gnt);
    assign xfer    = req_vld & req_rdy;

    always_comb begin
        hold_vld_d = hold_vld_q;
        cdb_d      = cdb_q;
        cdb_d.vld  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                cdb_d         = hold_q[i];
                cdb_d.vld     = 1'b1;
                hold_vld_d[i] = 1'b0;
            end
            if (xfer[i]) begin
                hold_vld_d[i] = 1'b1;
            end
        end
        if (flush) begin
            hold_vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q <= '0;
            cdb_q      <= '0;
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            hold_vld_q <= hold_vld_d;
            cdb_q      <= cdb_d;
            for (int i = 0; i < N; i++) begin
                if (xfer[i]) begin
                    hold_q[i] <= req_cdb[i*CDB_W +: CDB_W];
                end
            end
        end
    end

    assign cdb_o = cdb_q;
    assign busy  = |hold_vld_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) among the three functional-unit pipes: logic, arith and mpy. Each pipe hands a completed result to a one-entry holding register. One held result per cycle is granted and driven onto a registered CDB output, which reservation stations, the register-status table and the ROB snoop. The block provides back-pressure to each pipe and a flush path that discards in-flight results.

## Interface
- `N`, default 3: number of requesters. Index 0 = logic, 1 = arith, 2 = mpy.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_vld` in N: requester i offers `req_cdb[i]`.
- `req_cdb` in N×CDB_W: `cdb_t` payload (tag, wa, wdata, robid). The payload's `vld` bit is ignored.
- `req_rdy` out N: holding slot i accepts this cycle.
- `flush` in 1: discard all held results and the result on the output register.
- `cdb_o` out CDB_W: registered `cdb_t` broadcast. `cdb_o.vld` qualifies it.
- `busy` out 1: OR of all holding-slot valids.

## Operation
- A transfer occurs on requester i when `req_vld[i] & req_rdy[i]`. The payload is captured into `hold[i]`, and `hold_vld[i]` is set.
- `req_rdy[i] = ~flush & (~hold_vld[i] | gnt[i])`. A held entry that is granted frees its slot in the same cycle, so one result per cycle per requester can stream.
- `gnt` is one-hot or zero. It is computed only from `hold_vld` and the arbitration state, never from `req_vld`, so there is no combinational path from request to ready.
- Round-robin (see Configuration):
  - Pointer `last` holds the index of the most recent grant.
  - Search order is `last+1, last+2, …`, modulo N, wrapping from N-1 to 0.
  - `last` updates only when some grant occurs.
- On a grant of slot k:
  - `cdb_o` ← `{vld=1, hold[k] fields}` at the next edge.
  - `hold_vld[k]` clears unless a new transfer into k happens in the same cycle.
- No grant means `cdb_o.vld` ← 0 at the next edge; the payload fields hold their previous value.
- Flush:
  - All `hold_vld` clear at the next edge, and `cdb_o.vld` ← 0.
  - No grant is issued in the flush cycle. `req_rdy` is all 0 in that cycle.
  - `last` is unchanged.
- No deduplication or tag checking is performed. Requesters guarantee unique tags.

## Timing
- Reset values: `hold_vld`=0, `cdb_o`=0 (all fields), `last`=N-1 so that index 0 has first priority, `busy`=0, `req_rdy`=all 1.
- Latency: a transfer in cycle t is granted earliest in t+1 and appears with `cdb_o.vld`=1 in cycle t+2.
- Throughput: one CDB broadcast per cycle when any slot is held.
- Worst-case wait under round-robin with all slots continuously held: N-1 grants.
- Simultaneous grant of slot k and new transfer into k: the new payload is captured and `hold_vld[k]` stays 1.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Held results are lost.

## Configuration
- `CDB_ARB_RR_EN` defined: round-robin arbitration as above, using the `last` pointer register.
- `CDB_ARB_RR_EN` undefined: fixed priority with the highest index first (mpy > arith > logic), because the longest-latency pipe wins. The `last` register is not instantiated. Every other behaviour is identical.

## Structure
- Add to `tomasulo_pkg`:
  - `localparam int CDB_REQ_N = 3`
  - enum `cdb_req_t` {`CDB_REQ_LOGIC=0`, `CDB_REQ_ARITH=1`, `CDB_REQ_MPY=2`}
- Reuse the existing `cdb_t` and `robid_t` types.
- One sub-module, `cdb_arb_rr`: takes `N` request bits, produces a one-hot grant, and owns the `last` pointer. It contains the fixed-priority fallback under the macro.
- Holding slots and the output register live in `cdb_arbiter`.

## Test plan
- Reset, then a single request on index 1 with tag=5, wdata=0xDEAD_BEEF, robid=3 in cycle 0. Required: `cdb_o` shows vld=1, tag=5, wdata=0xDEADBEEF, robid=3 in cycle 2, and vld=0 in cycle 3.
- All three slots loaded in the same cycle with tags 1/2/3, no further requests, RR enabled. Required: broadcasts in order tag 1, 2, 3 on consecutive cycles, then `busy`=0.
- Same stimulus with `CDB_ARB_RR_EN` undefined. Required: order 3, 2, 1.
- Continuous back-to-back requests on all three pipes for 30 cycles, RR enabled. Required: 30 broadcasts after the pipe fills, the grant sequence cycles 0, 1, 2, …, no requester waits more than 2 grants, and no result is lost or duplicated (scoreboard on tag).
- `flush` asserted with two slots held and `cdb_o.vld`=1. Required: `req_rdy`=0 in the flush cycle, then `cdb_o.vld`=0 and `busy`=0 the next cycle, and none of the flushed tags ever appears on `cdb_o`.
- Assert `rst_n` low mid-stream with three slots held. Required: `cdb_o.vld`, `busy` and `hold_vld` read 0 while `rst_n` is still low, before any clock edge. After release, a request on index 0 is granted first.
